// File: rtl/fpu_pkg.sv
// Shared FPU result-buffer types: status width default, flag bit positions, slot record.
// Slot data fields are sized for the widest supported tag/status; users truncate to their widths.
package fpu_pkg;

   localparam int STAT_WIDTH_DEFAULT = 5;
   localparam int TAG_WIDTH_MAX      = 16;
   localparam int STAT_WIDTH_MAX     = 8;

   typedef enum int {
      FLAG_NX = 0,
      FLAG_UF = 1,
      FLAG_OF = 2,
      FLAG_DZ = 3,
      FLAG_NV = 4
   } fflag_idx_e;

   typedef struct packed {
      logic [TAG_WIDTH_MAX-1:0]  tag;
      logic [31:0]               res;
      logic [STAT_WIDTH_MAX-1:0] status;
      logic                      issued;
      logic                      done;
   } slot_t;

endpackage

// File: rtl/fp_fma_result_buffer_if.sv
// Issue / FMA-result / consumer signal bundle for the FMA result buffer.
interface fp_fma_result_buffer_if
   import fpu_pkg::*;
#(
   parameter int STAT_WIDTH = STAT_WIDTH_DEFAULT,
   parameter int TAG_WIDTH  = 5
) ();

   logic                  IssueValid_i;
   logic [TAG_WIDTH-1:0]  IssueTag_i;
   logic                  IssueReady_o;
   logic                  FmaValid_i;
   logic [31:0]           FmaRes_i;
   logic [STAT_WIDTH-1:0] FmaStatus_i;
   logic                  Valid_o;
   logic [31:0]           Res_o;
   logic [STAT_WIDTH-1:0] Status_o;
   logic [TAG_WIDTH-1:0]  Tag_o;
   logic                  Ack_i;
   logic [STAT_WIDTH-1:0] Fflags_o;
   logic                  FflagsClr_i;
   logic                  Err_o;

   modport slave (
      input  IssueValid_i, IssueTag_i, FmaValid_i, FmaRes_i, FmaStatus_i, Ack_i, FflagsClr_i,
      output IssueReady_o, Valid_o, Res_o, Status_o, Tag_o, Fflags_o, Err_o
   );

   modport master (
      output IssueValid_i, IssueTag_i, FmaValid_i, FmaRes_i, FmaStatus_i, Ack_i, FflagsClr_i,
      input  IssueReady_o, Valid_o, Res_o, Status_o, Tag_o, Fflags_o, Err_o
   );

endinterface

// File: rtl/fp_credit_cnt.sv
// Up/down credit counter, range 0..MAX; full when every credit is taken.
module fp_credit_cnt #(
   parameter int MAX = 4
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic inc_i,
   input  logic dec_i,
   output logic full_o
);

   localparam int CNT_W = $clog2(MAX + 1);

   logic [CNT_W-1:0] count_reg;
   logic [CNT_W-1:0] count_next;
   logic             inc_ok;
   logic             dec_ok;

   // Guards keep the count in range even if a caller misbehaves.
   assign inc_ok = inc_i && !full_o;
   assign dec_ok = dec_i && (count_reg != '0);

   always_comb begin
      count_next = count_reg;
      if (inc_ok && !dec_ok) begin
         count_next = count_reg + CNT_W'(1);
      end else if (dec_ok && !inc_ok) begin
         count_next = count_reg - CNT_W'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         count_reg <= '0;
      end else begin
         count_reg <= count_next;
      end
   end

   assign full_o = (count_reg == CNT_W'(MAX));

endmodule

// File: rtl/fp_fma_result_buffer.sv
// In-order result buffer between an FMA issuer and its consumer, with issue credits,
// sticky popped-status flags and a sticky error for unexpected result strobes.
module fp_fma_result_buffer
   import fpu_pkg::*;
#(
   parameter int DEPTH      = 4,
   parameter int STAT_WIDTH = STAT_WIDTH_DEFAULT,
   parameter int TAG_WIDTH  = 5
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   fp_fma_result_buffer_if.slave bus
);

   localparam int IDX_W = $clog2(DEPTH);
   localparam int PTR_W = IDX_W + 1;

   logic [PTR_W-1:0]      wr_tag_reg;
   logic [PTR_W-1:0]      wr_res_reg;
   logic [PTR_W-1:0]      rd_reg;
   logic [STAT_WIDTH-1:0] fflags_reg;
   logic [STAT_WIDTH-1:0] fflags_next;
   logic                  err_reg;

   slot_t [DEPTH-1:0]     slot_vec;
   slot_t                 head_slot;
   logic                  head_unused;
   logic [STAT_WIDTH-1:0] head_status;

   logic full;
   logic issue_fire;
   logic res_fire;
   logic res_drop;
   logic pop;

   // Full pointers (with wrap bit) distinguish "no outstanding op" from "all outstanding".
   assign issue_fire = bus.IssueValid_i && !full;
   assign res_fire   = bus.FmaValid_i && (wr_res_reg != wr_tag_reg);
   assign res_drop   = bus.FmaValid_i && (wr_res_reg == wr_tag_reg);
   assign pop        = head_slot.done && bus.Ack_i;

   fp_credit_cnt #(
      .MAX (DEPTH)
   ) u_credit (
      .clk_i  (clk_i),
      .rst_ni (rst_ni),
      .inc_i  (issue_fire),
      .dec_i  (pop),
      .full_o (full)
   );

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_slot
         slot_t slot_reg;

         // The three writers always target different slots, so their order here is irrelevant.
         always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
               slot_reg.issued <= 1'b0;
               slot_reg.done   <= 1'b0;
            end else begin
               if (issue_fire && (wr_tag_reg[IDX_W-1:0] == IDX_W'(gi))) begin
                  slot_reg.tag    <= TAG_WIDTH_MAX'(bus.IssueTag_i);
                  slot_reg.issued <= 1'b1;
               end
               if (res_fire && (wr_res_reg[IDX_W-1:0] == IDX_W'(gi))) begin
                  slot_reg.res    <= bus.FmaRes_i;
                  slot_reg.status <= STAT_WIDTH_MAX'(bus.FmaStatus_i);
                  slot_reg.done   <= 1'b1;
               end
               if (pop && (rd_reg[IDX_W-1:0] == IDX_W'(gi))) begin
                  slot_reg.issued <= 1'b0;
                  slot_reg.done   <= 1'b0;
               end
            end
         end

         assign slot_vec[gi] = slot_reg;
      end
   endgenerate

   assign head_slot   = slot_vec[rd_reg[IDX_W-1:0]];
   assign head_status = STAT_WIDTH'(head_slot.status);
   // Wide data fields and the issued bit are not all consumed at the head.
   assign head_unused = ^head_slot;

   always_comb begin
      fflags_next = fflags_reg;
      if (bus.FflagsClr_i) begin
         fflags_next = '0;
      end
      if (pop) begin
         fflags_next = fflags_next | head_status;
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         wr_tag_reg <= '0;
         wr_res_reg <= '0;
         rd_reg     <= '0;
         fflags_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         if (issue_fire) begin
            wr_tag_reg <= wr_tag_reg + PTR_W'(1);
         end
         if (res_fire) begin
            wr_res_reg <= wr_res_reg + PTR_W'(1);
         end
         if (pop) begin
            rd_reg <= rd_reg + PTR_W'(1);
         end
         if (res_drop) begin
            err_reg <= 1'b1;
         end
         fflags_reg <= fflags_next;
      end
   end

   assign bus.IssueReady_o = !full;
   assign bus.Valid_o      = head_slot.done;
   assign bus.Res_o        = head_slot.done ? head_slot.res : '0;
   assign bus.Status_o     = head_slot.done ? head_status : '0;
   assign bus.Tag_o        = head_slot.done ? TAG_WIDTH'(head_slot.tag) : '0;
   assign bus.Fflags_o     = fflags_reg;
   assign bus.Err_o        = err_reg;

endmodule

// File: tb/tb_fp_fma_result_buffer.sv
// Bench for fp_fma_result_buffer: directed vector table, corner sequences, random vs queue model.
module tb_fp_fma_result_buffer;

   localparam int DEPTH = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;

   always #5 clk = ~clk;

   fp_fma_result_buffer_if #(.STAT_WIDTH(5), .TAG_WIDTH(5)) bus ();

   fp_fma_result_buffer #(
      .DEPTH      (DEPTH),
      .STAT_WIDTH (5),
      .TAG_WIDTH  (5)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   int total = 0;
   int bad   = 0;

   // Reference model: outstanding ops in issue order; results arrive in the same order.
   bit [4:0]  m_tag[$];
   bit [31:0] m_res[$];
   bit [4:0]  m_st[$];
   bit [4:0]  m_ff;
   bit        m_err;

   typedef struct {
      bit        iv;
      bit [4:0]  itag;
      bit        fv;
      bit [31:0] fres;
      bit [4:0]  fst;
      bit        ack;
      bit        clr;
      bit        e_ready;
      bit        e_valid;
      bit [4:0]  e_tag;
      bit [31:0] e_res;
      bit [4:0]  e_st;
      bit [4:0]  e_ff;
      bit        e_err;
   } vec_t;

   vec_t vt[15];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic drive(input bit iv, input bit [4:0] itag, input bit fv, input bit [31:0] fres,
                        input bit [4:0] fst, input bit ack, input bit clr);
      bit       pop;
      bit [4:0] pst;
      bus.IssueValid_i = iv;
      bus.IssueTag_i   = itag;
      bus.FmaValid_i   = fv;
      bus.FmaRes_i     = fres;
      bus.FmaStatus_i  = fst;
      bus.Ack_i        = ack;
      bus.FflagsClr_i  = clr;
      @(posedge clk);
      pop = (m_res.size() > 0) && ack;
      pst = pop ? m_st[0] : 5'd0;
      if (fv) begin
         if (m_res.size() < m_tag.size()) begin
            m_res.push_back(fres);
            m_st.push_back(fst);
         end else begin
            m_err = 1'b1;
         end
      end
      if (iv && (m_tag.size() < DEPTH)) m_tag.push_back(itag);
      if (pop) begin
         $display("txn pop tag=%0d res=%h status=%b", m_tag[0], m_res[0], m_st[0]);
         void'(m_tag.pop_front());
         void'(m_res.pop_front());
         void'(m_st.pop_front());
      end
      if (clr) m_ff = pst;
      else if (pop) m_ff = m_ff | pst;
      #1;
   endtask

   task automatic idle();
      drive(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.IssueValid_i = 1'b0;
      bus.IssueTag_i   = '0;
      bus.FmaValid_i   = 1'b0;
      bus.FmaRes_i     = '0;
      bus.FmaStatus_i  = '0;
      bus.Ack_i        = 1'b0;
      bus.FflagsClr_i  = 1'b0;
      @(posedge clk);
      m_tag.delete();
      m_res.delete();
      m_st.delete();
      m_ff  = '0;
      m_err = 1'b0;
      #1;
      rst_n = 1'b1;
   endtask

   task automatic check_model(input string ctx);
      bit v;
      v = m_res.size() > 0;
      check({ctx, "_ready"},  bus.IssueReady_o, (m_tag.size() < DEPTH));
      check({ctx, "_valid"},  bus.Valid_o, v);
      check({ctx, "_tag"},    bus.Tag_o, v ? m_tag[0] : 5'd0);
      check({ctx, "_res"},    bus.Res_o, v ? m_res[0] : 32'd0);
      check({ctx, "_status"}, bus.Status_o, v ? m_st[0] : 5'd0);
      check({ctx, "_fflags"}, bus.Fflags_o, m_ff);
      check({ctx, "_err"},    bus.Err_o, m_err);
   endtask

   initial begin
      // iv itag fv fres fst ack clr | ready valid tag res status fflags err
      vt[0]  = '{1'b1, 5'd3, 1'b0, 32'h0,        5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00000, 1'b0};
      vt[1]  = '{1'b0, 5'd0, 1'b0, 32'h0,        5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00000, 1'b0};
      vt[2]  = '{1'b0, 5'd0, 1'b1, 32'h3F800000, 5'b00000, 1'b0, 1'b0, 1'b1, 1'b1, 5'd3, 32'h3F800000, 5'b00000, 5'b00000, 1'b0};
      vt[3]  = '{1'b0, 5'd0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00000, 1'b0};
      vt[4]  = '{1'b1, 5'd7, 1'b0, 32'h0,        5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00000, 1'b0};
      vt[5]  = '{1'b1, 5'd8, 1'b1, 32'h40000000, 5'b00001, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 32'h40000000, 5'b00001, 5'b00000, 1'b0};
      vt[6]  = '{1'b0, 5'd0, 1'b1, 32'h40400000, 5'b10000, 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h40400000, 5'b10000, 5'b00001, 1'b0};
      vt[7]  = '{1'b0, 5'd0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b10001, 1'b0};
      vt[8]  = '{1'b0, 5'd0, 1'b0, 32'h0,        5'b00000, 1'b0, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00000, 1'b0};
      vt[9]  = '{1'b1, 5'd2, 1'b0, 32'h0,        5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00000, 1'b0};
      vt[10] = '{1'b0, 5'd0, 1'b1, 32'h3F000000, 5'b00100, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 32'h3F000000, 5'b00100, 5'b00000, 1'b0};
      vt[11] = '{1'b0, 5'd0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00100, 1'b0};
      vt[12] = '{1'b1, 5'd4, 1'b0, 32'h0,        5'b00000, 1'b0, 1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00100, 1'b0};
      vt[13] = '{1'b0, 5'd0, 1'b1, 32'hBF800000, 5'b00010, 1'b0, 1'b0, 1'b1, 1'b1, 5'd4, 32'hBF800000, 5'b00010, 5'b00100, 1'b0};
      vt[14] = '{1'b0, 5'd0, 1'b0, 32'h0,        5'b00000, 1'b1, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0,        5'b00000, 5'b00010, 1'b0};

      do_reset();
      check("reset_ready", bus.IssueReady_o, 1'b1);
      check("reset_valid", bus.Valid_o, 1'b0);
      check("reset_fflags", bus.Fflags_o, 5'd0);
      check("reset_err", bus.Err_o, 1'b0);

      // Directed table: basic result, flag accumulation, clear, clear-with-pop.
      for (int i = 0; i < 15; i++) begin
         drive(vt[i].iv, vt[i].itag, vt[i].fv, vt[i].fres, vt[i].fst, vt[i].ack, vt[i].clr);
         $display("txn vec %0d valid=%0b tag=%0d res=%h fflags=%b", i, bus.Valid_o, bus.Tag_o,
                  bus.Res_o, bus.Fflags_o);
         check("vec_ready",  bus.IssueReady_o, vt[i].e_ready);
         check("vec_valid",  bus.Valid_o, vt[i].e_valid);
         check("vec_tag",    bus.Tag_o, vt[i].e_tag);
         check("vec_res",    bus.Res_o, vt[i].e_res);
         check("vec_status", bus.Status_o, vt[i].e_st);
         check("vec_fflags", bus.Fflags_o, vt[i].e_ff);
         check("vec_err",    bus.Err_o, vt[i].e_err);
      end

      // Credit exhaustion: fifth issue ignored, pop frees a credit only after the edge.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         drive(1'b1, 5'(k), 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
         check_model("fill");
      end
      check("full_ready", bus.IssueReady_o, 1'b0);
      drive(1'b1, 5'd9, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      check("ignored_issue_ready", bus.IssueReady_o, 1'b0);
      drive(1'b0, 5'd0, 1'b1, 32'h11, 5'd0, 1'b0, 1'b0);
      check("full_head_valid", bus.Valid_o, 1'b1);
      check("full_head_tag", bus.Tag_o, 5'd0);
      bus.Ack_i = 1'b1;
      #1;
      check("ready_same_cycle_as_pop", bus.IssueReady_o, 1'b0);
      drive(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
      check("ready_after_pop", bus.IssueReady_o, 1'b1);
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, 5'd0, 1'b1, 32'(k), 5'd0, 1'b0, 1'b0);
         check_model("drain_res");
      end
      for (int k = 1; k < 4; k++) begin
         drive(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
         check_model("drain_pop");
      end

      // Four done entries held, then popped in issue order; pointers wrap afterwards.
      do_reset();
      for (int k = 0; k < 4; k++) drive(1'b1, 5'(k), 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) drive(1'b0, 5'd0, 1'b1, 32'h100 + 32'(k), 5'd0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) begin
         idle();
         check("hold_tag", bus.Tag_o, 5'd0);
         check("hold_res", bus.Res_o, 32'h100);
      end
      for (int k = 0; k < 4; k++) begin
         check("pop_order_tag", bus.Tag_o, 5'(k));
         drive(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
      end
      check("drained_ready", bus.IssueReady_o, 1'b1);
      check("drained_valid", bus.Valid_o, 1'b0);
      drive(1'b1, 5'd5, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      drive(1'b0, 5'd0, 1'b1, 32'hABC, 5'b01000, 1'b0, 1'b0);
      check("wrap_tag", bus.Tag_o, 5'd5);
      check("wrap_res", bus.Res_o, 32'hABC);
      drive(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
      check_model("wrap_pop");

      // Result strobe with nothing outstanding.
      do_reset();
      drive(1'b0, 5'd0, 1'b1, 32'hDEAD, 5'b11111, 1'b0, 1'b0);
      check("orphan_err", bus.Err_o, 1'b1);
      check("orphan_valid", bus.Valid_o, 1'b0);
      idle();
      check_model("orphan_after");

      // Reset with buffered entries, then a stale strobe after reset.
      do_reset();
      for (int k = 1; k < 4; k++) drive(1'b1, 5'(k), 1'b0, 32'd0, 5'd0, 1'b0, 1'b0);
      for (int k = 1; k < 4; k++) drive(1'b0, 5'd0, 1'b1, 32'(k), 5'b00001, 1'b0, 1'b0);
      drive(1'b0, 5'd0, 1'b0, 32'd0, 5'd0, 1'b1, 1'b0);
      check("pre_reset_fflags", bus.Fflags_o, 5'b00001);
      check("pre_reset_valid", bus.Valid_o, 1'b1);
      do_reset();
      check("midrst_valid", bus.Valid_o, 1'b0);
      check("midrst_ready", bus.IssueReady_o, 1'b1);
      check("midrst_fflags", bus.Fflags_o, 5'd0);
      drive(1'b0, 5'd0, 1'b1, 32'h5, 5'd0, 1'b0, 1'b0);
      check("post_rst_strobe_err", bus.Err_o, 1'b1);
      check("post_rst_strobe_valid", bus.Valid_o, 1'b0);

      // Random traffic against the queue model.
      do_reset();
      for (int n = 0; n < 500; n++) begin
         bit        iv, fv, ack, clr;
         bit [4:0]  itag, fst;
         bit [31:0] fres;
         iv   = $urandom_range(0, 9) < 6;
         itag = 5'($urandom_range(0, 31));
         fv   = (m_res.size() < m_tag.size()) && ($urandom_range(0, 1) == 1);
         fres = $urandom;
         fst  = 5'($urandom_range(0, 31));
         ack  = $urandom_range(0, 2) != 0;
         clr  = $urandom_range(0, 9) == 0;
         drive(iv, itag, fv, fres, fst, ack, clr);
         check_model("rand");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
